// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: nextPc encodings from
// controlDecode and the fetch FSM state type.
package riscv_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EXEC,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target and misalignment flag.
// In: pc_i, nextPc_i, branch_i, branchTaken_i, immExt_i, rs1Data_i
// Out: target_o (next PC), misalign_o (target[1:0] != 0)
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      nextPc_i,
  input  logic            branch_i,
  input  logic            branchTaken_i,
  input  logic [XLEN-1:0] immExt_i,
  input  logic [XLEN-1:0] rs1Data_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] reg_pc;

  assign seq_pc = pc_i + XLEN'(4);
  assign rel_pc = pc_i + immExt_i;
  assign reg_pc = rs1Data_i + immExt_i;

  always_comb begin
    target_o = seq_pc;
    unique case (nextPc_i)
      NPC_PLUS4:  target_o = seq_pc;
      NPC_BRANCH: target_o = (branch_i && branchTaken_i)
                             ? rel_pc : seq_pc;
      NPC_JAL:    target_o = rel_pc;
      NPC_JALR:   target_o = {reg_pc[XLEN-1:1], 1'b0};
      default:    target_o = seq_pc;
    endcase
  end

  assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and instruction hold register.
// Ports: clk/rst_n, controlDecode inputs, retire, imem req/ready
// handshake, held instr/pcOut/pcPlus4 and sticky misaligned trap.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      nextPc,
  input  logic            branch,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] immExt,
  input  logic [XLEN-1:0] rs1Data,
  input  logic            retire,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemReady,
  input  logic [31:0]     imemRdata,
  output logic [31:0]     instr,
  output logic            instrValid,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlus4,
  output logic            misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] target;
  logic            tgt_mis;

  next_pc_calc #(.XLEN(XLEN)) u_npc (
    .pc_i          (pc_q),
    .nextPc_i      (nextPc),
    .branch_i      (branch),
    .branchTaken_i (branchTaken),
    .immExt_i      (immExt),
    .rs1Data_i     (rs1Data),
    .target_o      (target),
    .misalign_o    (tgt_mis)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (imemReady) begin
          instr_d = imemRdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          valid_d = 1'b0;
          // faulting target: keep pc of the offending instr
          if (ALIGN_CHECK && tgt_mis) begin
            mis_d   = 1'b1;
            req_d   = 1'b0;
            state_d = TRAP;
          end else begin
            pc_d    = target;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      TRAP: begin
        mis_d   = 1'b1;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= XLEN'(RESET_PC);
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign instrValid = valid_q;
  assign pcOut      = pc_q;
  assign pcPlus4    = pc_q + XLEN'(4);
  assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed boot/wait/trap/abort
// sequences, a vector table and a randomized model run.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  nextPc;
  logic        branch, branchTaken;
  logic [31:0] immExt, rs1Data;
  logic        retire;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pcOut, pcPlus4;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nextPc      (nextPc),
    .branch      (branch),
    .branchTaken (branchTaken),
    .immExt      (immExt),
    .rs1Data     (rs1Data),
    .retire      (retire),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemRdata   (imemRdata),
    .instr       (instr),
    .instrValid  (instrValid),
    .pcOut       (pcOut),
    .pcPlus4     (pcPlus4),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  npc;
    logic        br;
    logic        tk;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // spec-level target rule, plain arithmetic
  function automatic logic [31:0] ref_target(
    input logic [31:0] pc, input logic [1:0] npc,
    input logic br, input logic tk,
    input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    case (npc)
      2'd0: t = pc + 4;
      2'd1: t = (br && tk) ? pc + imm : pc + 4;
      2'd2: t = pc + imm;
      default: t = (rs1 + imm) & 32'hFFFF_FFFE;
    endcase
    return t;
  endfunction

  // from EXEC: retire with given controls, then fetch
  // after `waits` not-ready REQ cycles
  task automatic do_instr(input logic [1:0] npc,
                          input logic br, input logic tk,
                          input logic [31:0] imm,
                          input logic [31:0] rs1,
                          input logic [31:0] exp_pc,
                          input int waits,
                          input string tag);
    logic [31:0] d;
    nextPc = npc; branch = br; branchTaken = tk;
    immExt = imm; rs1Data = rs1;
    imemReady = 1'b0;
    retire = 1'b1;
    step();
    retire = 1'b0;
    nextPc = 2'($urandom); immExt = $urandom;
    chk({tag, "_req"}, 32'(imemReq), 32'd1);
    chk({tag, "_addr"}, imemAddr, exp_pc);
    chk({tag, "_vld0"}, 32'(instrValid), 32'd0);
    for (int w = 0; w < waits; w++) begin
      step();
      chk({tag, "_waddr"}, imemAddr, exp_pc);
    end
    d = $urandom;
    imemRdata = d;
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    chk({tag, "_vld"}, 32'(instrValid), 32'd1);
    chk({tag, "_instr"}, instr, d);
    chk({tag, "_pc"}, pcOut, exp_pc);
    chk({tag, "_pc4"}, pcPlus4, exp_pc + 32'd4);
    chk({tag, "_reqlo"}, 32'(imemReq), 32'd0);
  endtask

  task automatic boot();
    rst_n = 1'b0;
    imemReady = 1'b1;
    imemRdata = 32'h0000_0013;
    retire = 1'b0;
    repeat (3) step();
    chk("rst_req", 32'(imemReq), 32'd0);
    chk("rst_vld", 32'(instrValid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_pc", pcOut, 32'd0);
    rst_n = 1'b1;
    step();
    chk("boot_req", 32'(imemReq), 32'd1);
    chk("boot_addr", imemAddr, 32'd0);
    chk("boot_vld0", 32'(instrValid), 32'd0);
    step();
    chk("boot_vld", 32'(instrValid), 32'd1);
    chk("boot_instr", instr, 32'h0000_0013);
    chk("boot_req0", 32'(imemReq), 32'd0);
    imemReady = 1'b0;
  endtask

  logic [31:0] pc_m;

  initial begin
    vecs[0]  = '{2'b10, 1'b0, 1'b0, 32'h0000_00FC, 32'h0, 32'h0000_0100};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0104};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0108};
    vecs[3]  = '{2'b10, 1'b0, 1'b0, 32'h0000_00F8, 32'h0, 32'h0000_0200};
    vecs[4]  = '{2'b01, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0000_01F8};
    vecs[5]  = '{2'b10, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0200};
    vecs[6]  = '{2'b01, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_0204};
    vecs[7]  = '{2'b01, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0000_0208};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,         32'h41, 32'h0000_0040};
    vecs[9]  = '{2'b10, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0060};
    vecs[10] = '{2'b11, 1'b0, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000};

    nextPc = 2'b00; branch = 1'b0; branchTaken = 1'b0;
    immExt = '0; rs1Data = '0; retire = 1'b0;
    imemReady = 1'b0; imemRdata = '0; rst_n = 1'b0;

    boot();

    // wait states: 4 not-ready cycles, capture on the 5th
    nextPc = 2'b00;
    retire = 1'b1;
    step();
    retire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ws_req", 32'(imemReq), 32'd1);
      chk("ws_addr", imemAddr, 32'd4);
      retire = (i == 1);
      step();
      retire = 1'b0;
    end
    chk("ws_req5", 32'(imemReq), 32'd1);
    chk("ws_addr5", imemAddr, 32'd4);
    imemRdata = 32'hCAFE_0001;
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    chk("ws_vld", 32'(instrValid), 32'd1);
    chk("ws_instr", instr, 32'hCAFE_0001);

    // ready while holding in EXEC must not disturb instr
    imemRdata = 32'hDEAD_BEEF;
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    chk("exec_hold", instr, 32'hCAFE_0001);
    chk("exec_vld", 32'(instrValid), 32'd1);
    chk("exec_pc", pcOut, 32'd4);

    for (int v = 0; v < 12; v++)
      do_instr(vecs[v].npc, vecs[v].br, vecs[v].tk,
               vecs[v].imm, vecs[v].rs1, vecs[v].exp_pc,
               v % 3, $sformatf("vec%0d", v));

    // randomized run against the reference rule
    pc_m = 32'h0;
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  np;
      logic        b, t;
      logic [31:0] im, r1, e;
      np = 2'($urandom);
      b  = 1'($urandom);
      t  = 1'($urandom);
      im = $urandom & 32'hFFFF_FFFC;
      r1 = $urandom & 32'hFFFF_FFFD;
      e  = ref_target(pc_m, np, b, t, im, r1);
      do_instr(np, b, t, im, r1, e,
               int'($urandom_range(0, 3)), "rnd");
      pc_m = e;
    end

    // jalr to 0x1002 traps, pc held at faulting instr
    nextPc = 2'b11; immExt = 32'd2; rs1Data = 32'h1001;
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("trap_mis", 32'(misaligned), 32'd1);
    chk("trap_req", 32'(imemReq), 32'd0);
    chk("trap_vld", 32'(instrValid), 32'd0);
    chk("trap_pc", pcOut, pc_m);
    imemReady = 1'b1;
    retire = 1'b1;
    nextPc = 2'b00;
    repeat (3) step();
    retire = 1'b0;
    imemReady = 1'b0;
    chk("trap_stay", 32'(misaligned), 32'd1);
    chk("trap_req2", 32'(imemReq), 32'd0);
    chk("trap_pc2", pcOut, pc_m);
    rst_n = 1'b0;
    #1;
    chk("trap_clr", 32'(misaligned), 32'd0);
    chk("trap_rstpc", pcOut, 32'd0);

    // abort a pending fetch with an async reset
    boot();
    nextPc = 2'b10; immExt = 32'h40;
    retire = 1'b1;
    step();
    retire = 1'b0;
    step();
    chk("ab_req", 32'(imemReq), 32'd1);
    chk("ab_addr", imemAddr, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_req0", 32'(imemReq), 32'd0);
    chk("ab_vld0", 32'(instrValid), 32'd0);
    chk("ab_pc", imemAddr, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
